// File: rtl/xif_tracker_pkg.sv
// Shared types for the CV-X-IF offload tracker: entry lifecycle state and ring entry layout.
// IDs are stored at a fixed maximum width so the struct is independent of the tracker's X_ID_WIDTH.
package xif_tracker_pkg;

  localparam int unsigned XIF_ID_MAX_W = 16;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2,
    DONE      = 2'd3
  } entry_state_e;

  typedef struct packed {
    entry_state_e            state;
    logic [XIF_ID_MAX_W-1:0] id;
    logic                    wb;
    logic [4:0]              rd;
  } entry_t;

endpackage

// File: rtl/xif_tracker_cam.sv
// ID match over N tags: one-hot hit vector plus any-hit flag; purely combinational.
// Caller guarantees at most one valid tag equals the key (live IDs are unique).
module xif_tracker_cam #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]        key,
  input  logic [N-1:0]        tag_vld,
  input  logic [N-1:0][W-1:0] tags,
  output logic [N-1:0]        hit_vec,
  output logic                hit
);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N; i++) begin
      hit_vec[i] = tag_vld[i] && (tags[i] == key);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/xif_offload_tracker.sv
// In-order ring of DEPTH offloads: allocates IDs, issues commit/kill one cycle after retire_go,
// accepts out-of-order results (result_ready always high out of reset) and writes rf one cycle later.
module xif_offload_tracker
  import xif_tracker_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetb,
  output logic                     alloc_ok,
  output logic [X_ID_WIDTH-1:0]    alloc_id,
  input  logic                     issue_fire,
  input  logic                     issue_accept,
  input  logic                     issue_writeback,
  input  logic [4:0]               issue_rd,
  input  logic                     retire_go,
  input  logic                     retire_kill,
  output logic                     commit_valid,
  output logic [X_ID_WIDTH-1:0]    commit_id,
  output logic                     commit_kill,
  input  logic                     result_valid,
  output logic                     result_ready,
  input  logic [X_ID_WIDTH-1:0]    result_id,
  input  logic [4:0]               result_rd,
  input  logic                     result_we,
  input  logic [X_RFW_WIDTH-1:0]   result_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [X_RFW_WIDTH-1:0]   rf_wdata,
  input  logic [4:0]               hz_rs1,
  input  logic [4:0]               hz_rs2,
  output logic                     hz_busy,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     protocol_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  entry_t                 ent_q [DEPTH];
  entry_t                 ent_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       cptr_q, cptr_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [X_ID_WIDTH-1:0]  id_ctr_q, id_ctr_d;
  logic                   commit_valid_q, commit_valid_d;
  logic [X_ID_WIDTH-1:0]  commit_id_q, commit_id_d;
  logic                   commit_kill_q, commit_kill_d;
  logic                   rf_we_q, rf_we_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [X_RFW_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                   err_q, err_d;

  logic [DEPTH-1:0]                   cam_vld;
  logic [DEPTH-1:0][XIF_ID_MAX_W-1:0] cam_tags;
  logic [DEPTH-1:0]                   res_hit_vec;
  logic                               res_hit;
  logic [PTR_W-1:0]                   res_idx;
  logic [OCC_W-1:0]                   occ;

  // Only COMMITTED entries may take a result; ISSUED/DONE/FREE never match.
  always_comb begin
    cam_vld  = '0;
    cam_tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cam_vld[i]  = (ent_q[i].state == COMMITTED);
      cam_tags[i] = ent_q[i].id;
    end
  end

  xif_tracker_cam #(
    .N (DEPTH),
    .W (XIF_ID_MAX_W)
  ) u_cam (
    .key     (XIF_ID_MAX_W'(result_id)),
    .tag_vld (cam_vld),
    .tags    (cam_tags),
    .hit_vec (res_hit_vec),
    .hit     (res_hit)
  );

  always_comb begin
    res_idx = '0;
    occ     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (res_hit_vec[i]) res_idx = PTR_W'(i);
      if (ent_q[i].state != FREE) occ = occ + OCC_W'(1);
    end
  end

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    cptr_d         = cptr_q;
    tail_d         = tail_q;
    id_ctr_d       = id_ctr_q;
    commit_valid_d = 1'b0;
    commit_id_d    = commit_id_q;
    commit_kill_d  = commit_kill_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    err_d          = err_q;

    if (ent_q[head_q].state == DONE) begin
      ent_d[head_q].state = FREE;
      head_d              = head_q + 1'b1;
    end

    if (issue_fire) begin
      if (!alloc_ok) begin
        err_d = 1'b1;
      end else if (issue_accept) begin
        ent_d[tail_q].state = ISSUED;
        ent_d[tail_q].id    = XIF_ID_MAX_W'(id_ctr_q);
        ent_d[tail_q].wb    = issue_writeback;
        ent_d[tail_q].rd    = issue_rd;
        tail_d              = tail_q + 1'b1;
        id_ctr_d            = id_ctr_q + 1'b1;
      end
    end

    // Decided on registered state, so an entry issued this cycle is not yet committable.
    if (retire_go) begin
      if (ent_q[cptr_q].state == ISSUED) begin
        ent_d[cptr_q].state = retire_kill ? DONE : COMMITTED;
        commit_valid_d      = 1'b1;
        commit_id_d         = ent_q[cptr_q].id[X_ID_WIDTH-1:0];
        commit_kill_d       = retire_kill;
        cptr_d              = cptr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (result_valid && result_ready) begin
      if (res_hit) begin
        ent_d[res_idx].state = DONE;
        if (result_we && ent_q[res_idx].wb) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = ent_q[res_idx].rd;
          rf_wdata_d = result_data;
          if (result_rd != ent_q[res_idx].rd) err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q         <= '0;
      cptr_q         <= '0;
      tail_q         <= '0;
      id_ctr_q       <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q         <= head_d;
      cptr_q         <= cptr_d;
      tail_q         <= tail_d;
      id_ctr_q       <= id_ctr_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_kill_q  <= commit_kill_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    alloc_ok     = (occ < OCC_W'(DEPTH));
    alloc_id     = id_ctr_q;
    outstanding  = occ;
    result_ready = !resetb;
    hz_busy      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((ent_q[i].state == ISSUED) || (ent_q[i].state == COMMITTED)) &&
          ent_q[i].wb && (ent_q[i].rd != 5'd0) &&
          ((ent_q[i].rd == hz_rs1) || (ent_q[i].rd == hz_rs2))) begin
        hz_busy = 1'b1;
      end
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign commit_kill  = commit_kill_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Bench for xif_offload_tracker: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against an in-order queue model of outstanding offloads.
module tb_xif_offload_tracker;

  localparam int IDW   = 4;
  localparam int DEPTH = 4;
  localparam int RFW   = 32;
  localparam int OCCW  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetb;
  logic            alloc_ok;
  logic [IDW-1:0]  alloc_id;
  logic            issue_fire, issue_accept, issue_writeback;
  logic [4:0]      issue_rd;
  logic            retire_go, retire_kill;
  logic            commit_valid;
  logic [IDW-1:0]  commit_id;
  logic            commit_kill;
  logic            result_valid;
  logic            result_ready;
  logic [IDW-1:0]  result_id;
  logic [4:0]      result_rd;
  logic            result_we;
  logic [RFW-1:0]  result_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [RFW-1:0]  rf_wdata;
  logic [4:0]      hz_rs1, hz_rs2;
  logic            hz_busy;
  logic [OCCW-1:0] outstanding;
  logic            protocol_err;

  xif_offload_tracker #(.X_ID_WIDTH(IDW), .DEPTH(DEPTH), .X_RFW_WIDTH(RFW)) dut (
    .clk(clk), .resetb(resetb), .alloc_ok(alloc_ok), .alloc_id(alloc_id),
    .issue_fire(issue_fire), .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .issue_rd(issue_rd), .retire_go(retire_go), .retire_kill(retire_kill),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_rd(result_rd), .result_we(result_we), .result_data(result_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_busy(hz_busy),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  // Model: queue of live offloads, oldest first. ph: 1 issued, 2 committed, 3 done.
  typedef struct { int id; bit wb; int rd; int ph; } rec_t;
  rec_t        mq[$];
  int          m_idctr, m_cid, m_rfa;
  bit          m_cv, m_ck, m_rfwe, m_err;
  logic [31:0] m_rfd;
  rec_t        nq[$];
  int          n_idctr, n_cid, n_rfa;
  bit          n_cv, n_ck, n_rfwe, n_err;
  logic [31:0] n_rfd;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ci, ri;
    bit pop;
    nq = mq; n_idctr = m_idctr; n_cv = 1'b0; n_ck = m_ck; n_cid = m_cid;
    n_rfwe = 1'b0; n_rfa = m_rfa; n_rfd = m_rfd; n_err = m_err;
    if (resetb) begin
      nq.delete(); n_idctr = 0; n_ck = 1'b0; n_cid = 0; n_rfa = 0; n_rfd = '0; n_err = 1'b0;
      return;
    end
    pop = (mq.size() > 0) && (mq[0].ph == 3);
    if (issue_fire) begin
      if (mq.size() >= DEPTH) n_err = 1'b1;
      else if (issue_accept) begin
        nq.push_back('{id: m_idctr, wb: issue_writeback, rd: int'(issue_rd), ph: 1});
        n_idctr = (m_idctr + 1) % (1 << IDW);
      end
    end
    if (retire_go) begin
      ci = -1;
      for (int i = 0; i < mq.size(); i++) if (ci < 0 && mq[i].ph == 1) ci = i;
      if (ci < 0) n_err = 1'b1;
      else begin
        nq[ci].ph = retire_kill ? 3 : 2;
        n_cv = 1'b1; n_cid = mq[ci].id; n_ck = retire_kill;
      end
    end
    if (result_valid) begin
      ri = -1;
      for (int i = 0; i < mq.size(); i++) if (mq[i].ph == 2 && mq[i].id == int'(result_id)) ri = i;
      if (ri < 0) n_err = 1'b1;
      else begin
        nq[ri].ph = 3;
        if (result_we && mq[ri].wb) begin
          n_rfwe = 1'b1; n_rfa = mq[ri].rd; n_rfd = result_data;
          if (int'(result_rd) != mq[ri].rd) n_err = 1'b1;
        end
      end
    end
    if (pop) void'(nq.pop_front());
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    mq = nq; m_idctr = n_idctr; m_cv = n_cv; m_ck = n_ck; m_cid = n_cid;
    m_rfwe = n_rfwe; m_rfa = n_rfa; m_rfd = n_rfd; m_err = n_err;
    #2;
  endtask

  task automatic idle();
    issue_fire = 0; issue_accept = 0; issue_writeback = 0; issue_rd = 0;
    retire_go = 0; retire_kill = 0;
    result_valid = 0; result_id = 0; result_rd = 0; result_we = 0; result_data = 0;
    hz_rs1 = 0; hz_rs2 = 0;
  endtask

  task automatic do_reset();
    idle(); resetb = 1; cyc(); resetb = 0;
  endtask

  task automatic issue(input int rd, input bit wb);
    idle(); issue_fire = 1; issue_accept = 1; issue_writeback = wb; issue_rd = 5'(rd);
  endtask

  task automatic res(input int id, input int rd, input bit we, input logic [31:0] d);
    idle(); result_valid = 1; result_id = IDW'(id); result_rd = 5'(rd); result_we = we; result_data = d;
  endtask

  always @(negedge clk) begin : cmp_proc
    bit hz;
    if (started) begin
      hz = 1'b0;
      foreach (mq[i])
        if ((mq[i].ph == 1 || mq[i].ph == 2) && mq[i].wb && mq[i].rd != 0 &&
            (mq[i].rd == int'(hz_rs1) || mq[i].rd == int'(hz_rs2))) hz = 1'b1;
      chk("alloc_ok", alloc_ok, mq.size() < DEPTH);
      chk("alloc_id", alloc_id, m_idctr);
      chk("outstanding", outstanding, mq.size());
      chk("hz_busy", hz_busy, hz);
      chk("result_ready", result_ready, !resetb);
      chk("commit_valid", commit_valid, m_cv);
      if (m_cv) begin
        chk("commit_id", commit_id, m_cid);
        chk("commit_kill", commit_kill, m_ck);
      end
      chk("rf_we", rf_we, m_rfwe);
      if (m_rfwe) begin
        chk("rf_waddr", rf_waddr, m_rfa);
        chk("rf_wdata", rf_wdata, m_rfd);
      end
      chk("protocol_err", protocol_err, m_err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cl[$];
    int k;
    idle(); resetb = 1;
    cyc(); started = 1; cyc();
    chk("rst_commit_id", commit_id, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_result_ready", result_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_alloc_ok", alloc_ok, 1);
    resetb = 0; cyc();
    chk("ready_after_rst", result_ready, 1);

    // Three issues, three commits, out-of-order results.
    for (int i = 0; i < 3; i++) begin
      chk("alloc_id_seq", alloc_id, i);
      issue(5 + i, 1); cyc();
    end
    idle();
    chk("outst_3", outstanding, 3);
    hz_rs1 = 6; #1;
    chk("hz_rd6", hz_busy, 1);
    idle(); retire_go = 1; cyc();
    chk("c0_valid", commit_valid, 1);
    chk("c0_id", commit_id, 0);
    chk("c0_kill", commit_kill, 0);
    cyc(); cyc();
    idle(); cyc();
    chk("commit_one_cycle", commit_valid, 0);
    res(2, 7, 1, 32'hA); cyc();
    chk("r2_we", rf_we, 1); chk("r2_addr", rf_waddr, 7); chk("r2_data", rf_wdata, 32'hA);
    chk("r2_outst", outstanding, 3);
    res(0, 5, 1, 32'hB); cyc();
    chk("r0_we", rf_we, 1); chk("r0_addr", rf_waddr, 5); chk("r0_data", rf_wdata, 32'hB);
    chk("r0_outst", outstanding, 3);
    res(1, 6, 1, 32'hC); cyc();
    chk("r1_we", rf_we, 1); chk("r1_addr", rf_waddr, 6); chk("r1_data", rf_wdata, 32'hC);
    chk("r1_outst", outstanding, 2);
    idle(); cyc();
    chk("rf_we_one_cycle", rf_we, 0);
    cyc();
    chk("drained", outstanding, 0);

    // Fill, overflow issue, then free the head.
    for (int i = 0; i < DEPTH; i++) begin issue(1 + i, 1); cyc(); end
    idle();
    chk("full_alloc_ok", alloc_ok, 0);
    issue(9, 1); cyc();
    chk("overflow_err", protocol_err, 1);
    chk("overflow_outst", outstanding, DEPTH);
    idle(); retire_go = 1; cyc();
    res(3, 1, 1, 32'h33); cyc();
    idle();
    chk("still_full", alloc_ok, 0);
    cyc();
    chk("alloc_restored", alloc_ok, 1);

    // Kill then stale result.
    do_reset(); cyc();
    issue(9, 1); cyc();
    idle(); retire_go = 1; retire_kill = 1; cyc();
    chk("kill_valid", commit_valid, 1);
    chk("kill_flag", commit_kill, 1);
    chk("kill_err_clear", protocol_err, 0);
    res(0, 9, 1, 32'h55); cyc();
    idle();
    chk("kill_no_rfwe", rf_we, 0);
    chk("kill_result_err", protocol_err, 1);
    cyc();

    // ID wrap over 20 sequential transactions.
    do_reset(); cyc();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_alloc_id", alloc_id, i % 16);
      issue((i % 31) + 1, 1); cyc();
      idle(); retire_go = 1; cyc();
      res(i % 16, (i % 31) + 1, 1, 32'(i)); cyc();
      chk("wrap_rf_we", rf_we, 1);
      idle(); cyc();
    end
    chk("wrap_no_err", protocol_err, 0);

    // Reset with two committed entries.
    do_reset(); cyc();
    issue(3, 1); cyc(); issue(4, 1); cyc();
    idle(); retire_go = 1; cyc(); cyc();
    do_reset();
    idle();
    chk("rst_mid_outst", outstanding, 0);
    res(0, 3, 1, 32'h77); cyc();
    idle();
    chk("rst_mid_err0", protocol_err, 1);
    chk("rst_mid_nowe0", rf_we, 0);
    do_reset();
    res(1, 4, 1, 32'h78); cyc();
    idle();
    chk("rst_mid_err1", protocol_err, 1);
    cyc();

    // Randomized traffic, mostly legal, in segments separated by resets.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        idle();
        if ($urandom_range(0, 99) < 45 && (mq.size() < DEPTH || $urandom_range(0, 29) == 0)) begin
          issue_fire = 1;
          issue_accept = ($urandom_range(0, 3) != 0);
          issue_writeback = $urandom_range(0, 1);
          issue_rd = 5'($urandom_range(0, 7));
        end
        k = 0;
        foreach (mq[i]) if (mq[i].ph == 1) k++;
        if ($urandom_range(0, 99) < 40 && (k > 0 || $urandom_range(0, 39) == 0)) begin
          retire_go = 1;
          retire_kill = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 99) < 45) begin
          cl.delete();
          foreach (mq[i]) if (mq[i].ph == 2) cl.push_back(i);
          result_valid = 1;
          result_we = ($urandom_range(0, 7) != 0);
          result_data = $urandom;
          if (cl.size() > 0 && $urandom_range(0, 39) != 0) begin
            k = cl[$urandom_range(0, cl.size() - 1)];
            result_id = IDW'(mq[k].id);
            result_rd = ($urandom_range(0, 39) == 0) ? 5'(mq[k].rd + 1) : 5'(mq[k].rd);
          end else begin
            result_id = IDW'($urandom_range(0, 15));
            result_rd = 5'($urandom_range(0, 7));
          end
        end
        hz_rs1 = 5'($urandom_range(0, 7));
        hz_rs2 = 5'($urandom_range(0, 7));
        resetb = ($urandom_range(0, 149) == 0);
        cyc();
      end
    end
    idle(); resetb = 0; cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
